conway_frame_engine: RTL

- Frame-buffered Game-of-Life engine with AXI-Stream in and out.
- Loads one WIDTH x HEIGHT frame of colour pixels and thresholds each pixel to a cell state.
- Runs a runtime-selectable number of generations internally on ping-pong state arrays, with a runtime birth/survive rule and dead or toroidal borders.
- Streams the result back out as colour pixels; sits between the input DMA stream and the output video/DMA stream.

---
 rtl/conway_frame_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/conway_frame_engine.sv
// Frame-buffered Game-of-Life engine: loads a colour frame over AXI-Stream,
// thresholds it to cells, runs a programmable number of generations on two
// ping-pong cell arrays and streams the result back out as colours.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_LOAD    | accept input beats into array A, latch config at frame end
// S_COMPUTE | one cell per cycle, current array -> other array, G passes
// S_STREAM  | emit current array as colours, one beat per handshake
module conway_frame_engine #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int GEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] alive_color,
  input  logic [DWIDTH-1:0] dead_color,
  input  logic [8:0]        rule_birth,
  input  logic [8:0]        rule_survive,
  input  logic              wrap_en,
  input  logic [GEN_W-1:0]  generations,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [DWIDTH-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic              busy,
  output logic              frame_done,
  output logic              tlast_err
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(N);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int COL_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_STREAM} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      cells_a_q, cells_a_d;
  logic [N-1:0]      cells_b_q, cells_b_d;
  logic              sel_q, sel_d;          // 1: array B holds the current generation
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [DWIDTH-1:0] alive_q, alive_d;
  logic [DWIDTH-1:0] dead_q, dead_d;
  logic [8:0]        birth_q, birth_d;
  logic [8:0]        surv_q, surv_d;
  logic              wrap_q, wrap_d;
  logic              frame_done_q, frame_done_d;
  logic              tlast_err_q, tlast_err_d;

  logic [N-1:0]      cur_cells;
  logic              last_cell;
  logic              advance;
  logic [3:0]        nbr_cnt;
  logic              next_cell;

  assign cur_cells = sel_q ? cells_b_q : cells_a_q;
  assign last_cell = (idx_q == IDX_W'(N - 1));

  // Neighbour lookup with either toroidal wrap or dead out-of-range cells.
  function automatic logic cell_at(input logic [N-1:0] arr, input int r, input int c,
                                   input logic wrap);
    int rr;
    int cc;
    logic [IDX_W-1:0] i;
    rr = r;
    cc = c;
    if (wrap) begin
      if (rr < 0) rr = HEIGHT - 1;
      else if (rr >= HEIGHT) rr = 0;
      if (cc < 0) cc = WIDTH - 1;
      else if (cc >= WIDTH) cc = 0;
    end else if (rr < 0 || rr >= HEIGHT || cc < 0 || cc >= WIDTH) begin
      return 1'b0;
    end
    i = IDX_W'(rr * WIDTH + cc);
    return arr[i];
  endfunction

  // Live-neighbour count of the cell at (row_q, col_q) and its next state.
  always_comb begin
    nbr_cnt = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0)
          nbr_cnt = nbr_cnt + {3'b000, cell_at(cur_cells, int'(row_q) + dr,
                                               int'(col_q) + dc, wrap_q)};
      end
    end
    next_cell = cur_cells[idx_q] ? surv_q[nbr_cnt] : birth_q[nbr_cnt];
  end

  // Next-state logic for the FSM, cell arrays, counters and latched config.
  always_comb begin
    state_d      = state_q;
    cells_a_d    = cells_a_q;
    cells_b_d    = cells_b_q;
    sel_d        = sel_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    gen_d        = gen_q;
    alive_d      = alive_q;
    dead_d       = dead_q;
    birth_d      = birth_q;
    surv_d       = surv_q;
    wrap_d       = wrap_q;
    frame_done_d = 1'b0;
    tlast_err_d  = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (S_AXIS_TVALID) begin
          cells_a_d[idx_q] = (S_AXIS_TDATA == alive_color);
          if (S_AXIS_TLAST || last_cell) begin
            // Cells past an early TLAST are already dead: A is cleared before every LOAD.
            tlast_err_d = (S_AXIS_TLAST != last_cell);
            alive_d     = alive_color;
            dead_d      = dead_color;
            birth_d     = rule_birth;
            surv_d      = rule_survive;
            wrap_d      = wrap_en;
            gen_d       = generations;
            idx_d       = '0;
            row_d       = '0;
            col_d       = '0;
            state_d     = (generations != '0) ? S_COMPUTE : S_STREAM;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (sel_q) cells_a_d[idx_q] = next_cell;
        else       cells_b_d[idx_q] = next_cell;
        if (last_cell) begin
          idx_d = '0;
          row_d = '0;
          col_d = '0;
          sel_d = ~sel_q;
          gen_d = gen_q - GEN_W'(1);
          if (gen_q == GEN_W'(1)) state_d = S_STREAM;
        end else begin
          advance = 1'b1;
        end
      end
      S_STREAM: begin
        if (M_AXIS_TREADY) begin
          if (last_cell) begin
            idx_d        = '0;
            row_d        = '0;
            col_d        = '0;
            sel_d        = 1'b0;
            cells_a_d    = '0;
            cells_b_d    = '0;
            frame_done_d = 1'b1;
            state_d      = S_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (advance) begin
      idx_d = idx_q + 1'b1;
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset that also flushes both cell arrays.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      cells_a_q    <= '0;
      cells_b_q    <= '0;
      sel_q        <= 1'b0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      gen_q        <= '0;
      alive_q      <= '0;
      dead_q       <= '0;
      birth_q      <= '0;
      surv_q       <= '0;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tlast_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cells_a_q    <= cells_a_d;
      cells_b_q    <= cells_b_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      gen_q        <= gen_d;
      alive_q      <= alive_d;
      dead_q       <= dead_d;
      birth_q      <= birth_d;
      surv_q       <= surv_d;
      wrap_q       <= wrap_d;
      frame_done_q <= frame_done_d;
      tlast_err_q  <= tlast_err_d;
    end
  end

  assign S_AXIS_TREADY = (state_q == S_LOAD) && !rst;
  assign M_AXIS_TVALID = (state_q == S_STREAM);
  assign M_AXIS_TLAST  = (state_q == S_STREAM) && last_cell;
  assign M_AXIS_TDATA  = (state_q != S_STREAM) ? '0 :
                         (cur_cells[idx_q] ? alive_q : dead_q);
  assign busy          = (state_q != S_LOAD);
  assign frame_done    = frame_done_q;
  assign tlast_err     = tlast_err_q;

endmodule
